uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// default lock timeout and a pointer-width helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  localparam int LOCK_TIMEOUT_DEF = 1024;

  // Width of a requester index; at least one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating first-valid search: returns the first set bit of
// i_valid at or after i_ptr, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx
);

  // Walk the N positions starting at the pointer; the first hit wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] j;
    o_onehot = '0;
    o_idx    = '0;
    found    = 1'b0;
    j        = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(i_ptr) + k) % N);
      if (!found && i_valid[j]) begin
        found       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from N requesters into one UART
// transmitter. States: ARB (pick owner), SEND (offer byte until the
// transmitter is idle), HOLD (one cycle so the transmitter's IDLE can fall).
// Handshake: a byte is taken on the rising edge where UART_DATA_READY and
// UART_IDLE are both high; REQ_ACK[owner] is high for the following cycle.
// Requesters keep REQ_VALID/REQ_DATA stable from grant until that ACK.
// Optional build macro UART_ARB_LOCK_EN: packet lock keyed on REQ_LAST with
// a LOCK_TIMEOUT release when the owner goes quiet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N            = 4,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N-1:0]   REQ_VALID,
  input  logic [8*N-1:0] REQ_DATA,
  input  logic [N-1:0]   REQ_LAST,
  output logic [N-1:0]   REQ_ACK,
  output logic [N-1:0]   GRANT,
  output logic [7:0]     UART_DATA,
  output logic           UART_DATA_READY,
  input  logic           UART_IDLE
);

  localparam int PW = ptr_width(N);

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_ack;
  logic [7:0]    r_data;
  logic          r_ready;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_pick_oh;
  logic [PW-1:0] w_pick_idx;
  logic [7:0]    w_pick_data;
  logic [PW-1:0] w_owner_inc;
  logic          w_do_grant;
  logic          w_take;

  assign w_take      = (r_state == ST_SEND) && r_ready && UART_IDLE;
  assign w_do_grant  = (r_state == ST_ARB) && (|w_elig) && UART_IDLE;
  assign w_owner_inc = (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .i_valid  (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  // Byte of the picked requester.
  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_oh[i]) w_pick_data = w_pick_data | REQ_DATA[8*i +: 8];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_ARB;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ARB:  if (w_do_grant) w_next_state = ST_SEND;
      ST_SEND: if (w_take)     w_next_state = ST_HOLD;
      ST_HOLD: w_next_state = ST_ARB;
      default: w_next_state = ST_ARB;
    endcase
  end

  // Grant, byte register, DATA_READY and the one-cycle ACK pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_grant <= '0;
      r_owner <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_ARB: begin
          if (w_do_grant) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_data  <= w_pick_data;
            r_ready <= 1'b1;
          end else begin
            r_grant <= '0;
          end
        end
        ST_SEND: begin
          if (w_take) begin
            r_ready <= 1'b0;
            r_ack   <= r_grant;
          end
        end
        ST_HOLD: r_grant <= '0;
        default: r_grant <= '0;
      endcase
    end
  end

`ifdef UART_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic          r_lock;
  logic [CW-1:0] r_tmo_cnt;
  logic [N-1:0]  w_owner_mask;
  logic          w_tmo_hit;

  assign w_owner_mask = N'(1) << r_owner;
  // The release takes effect in the same ARB cycle the count expires.
  assign w_tmo_hit    = (r_state == ST_ARB) && r_lock && !REQ_VALID[r_owner] &&
                        (r_tmo_cnt == CW'(LOCK_TIMEOUT - 1));
  assign w_elig       = (r_lock && !w_tmo_hit) ? (REQ_VALID & w_owner_mask)
                                               : REQ_VALID;

  // Pointer, packet lock and idle-owner timeout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_tmo_cnt <= '0;
    end else if (w_take) begin
      r_tmo_cnt <= '0;
      if (REQ_LAST[r_owner]) begin
        r_lock <= 1'b0;
        r_ptr  <= w_owner_inc;
      end else begin
        r_lock <= 1'b1;
      end
    end else if ((r_state == ST_ARB) && r_lock && !REQ_VALID[r_owner]) begin
      if (w_tmo_hit) begin
        r_lock    <= 1'b0;
        r_ptr     <= w_owner_inc;
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused;

  assign w_elig   = REQ_VALID;
  assign w_unused = ^{REQ_LAST, 32'(LOCK_TIMEOUT)};

  // Pointer moves past the owner after every byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      r_ptr <= '0;
    else if (w_take) r_ptr <= w_owner_inc;
  end
`endif

  assign GRANT           = r_grant;
  assign REQ_ACK         = r_ack;
  assign UART_DATA       = r_data;
  assign UART_DATA_READY = r_ready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model, requester
// sources and an expected-byte scoreboard. Lock scenarios are compiled
// in when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 16;

  logic           CLK;
  logic           RST_N;
  logic [N-1:0]   REQ_VALID;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_LAST;
  logic [N-1:0]   REQ_ACK;
  logic [N-1:0]   GRANT;
  logic [7:0]     UART_DATA;
  logic           UART_DATA_READY;
  logic           UART_IDLE;

  uart_tx_arbiter #(.N(N), .LOCK_TIMEOUT(LT)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .REQ_VALID       (REQ_VALID),
    .REQ_DATA        (REQ_DATA),
    .REQ_LAST        (REQ_LAST),
    .REQ_ACK         (REQ_ACK),
    .GRANT           (GRANT),
    .UART_DATA       (UART_DATA),
    .UART_DATA_READY (UART_DATA_READY),
    .UART_IDLE       (UART_IDLE)
  );

  // Clock and watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard and bench state
  logic [11:0] exp_q[$];          // {grant one-hot, byte}
  logic [N-1:0] exp_ack;
  int n_vec, n_err;
  int cyc, last_take, take_cnt;
  int frame, tx_cnt;
  bit fall_pending, force_busy, chk_rate;

  logic [7:0] src_data [N][4];
  logic       src_last [N][4];
  int         src_len  [N];
  int         src_pos  [N];
  logic [N-1:0] kill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester drivers
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i] && !kill[i]) begin
        REQ_VALID[i]       = 1'b1;
        REQ_DATA[8*i +: 8] = src_data[i][src_pos[i]];
        REQ_LAST[i]        = src_last[i][src_pos[i]];
      end else begin
        REQ_VALID[i]       = 1'b0;
        REQ_DATA[8*i +: 8] = kill[i] ? 8'hEE : 8'h00;
        REQ_LAST[i]        = kill[i];
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    kill = '0;
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    src_data[i][src_len[i]] = d;
    src_last[i][src_len[i]] = l;
    src_len[i]++;
  endtask

  task automatic push(input logic [3:0] oh, input logic [7:0] d);
    exp_q.push_back({oh, d});
  endtask

  // One clock: transmitter model, ACK check, take check, requester update.
  task automatic step();
    logic [11:0] e;
    @(negedge CLK);
    cyc++;
    if (tx_cnt > 0) tx_cnt--;
    if (fall_pending) begin
      fall_pending = 1'b0;
      tx_cnt       = frame;
    end
    UART_IDLE = !force_busy && (tx_cnt == 0);
    check("ack", 32'(REQ_ACK), 32'(exp_ack));
    exp_ack = '0;
    if (RST_N && UART_DATA_READY && UART_IDLE) begin
      check("take_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("grant", 32'(GRANT), 32'(e[11:8]));
        check("data", 32'(UART_DATA), 32'(e[7:0]));
        exp_ack = e[11:8];
      end
      if (chk_rate && last_take >= 0) check("rate", 32'(cyc - last_take), 32'(frame + 2));
      last_take    = cyc;
      fall_pending = 1'b1;
      take_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      if (REQ_ACK[i]) begin
        src_pos[i]++;
        kill[i] = 1'b0;
      end
    end
    drive_reqs();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || UART_DATA_READY || tx_cnt != 0 || fall_pending ||
            GRANT != 0) && n < budget) begin
      step();
      n++;
    end
    check("done_in_time", 32'(n < budget), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int base, n, k;
    n_vec = 0; n_err = 0; cyc = 0; last_take = -1; take_cnt = 0;
    frame = 6; tx_cnt = 0; fall_pending = 0; force_busy = 0; chk_rate = 0;
    exp_ack = '0;
    RST_N = 1'b0; REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0; UART_IDLE = 1'b1;
    clear_src();

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_grant", 32'(GRANT), 32'd0);
    check("rst_ack", 32'(REQ_ACK), 32'd0);
    check("rst_data", 32'(UART_DATA), 32'd0);
    check("rst_ready", 32'(UART_DATA_READY), 32'd0);
    RST_N = 1'b1;

    // Single requester 2, latency grant +1, ACK +2
    load(2, 8'h55, 1'b1);
    push(4'b0100, 8'h55);
    drive_reqs();
    step();
    check("t1_grant", 32'(GRANT), 32'h4);
    check("t1_data", 32'(UART_DATA), 32'h55);
    check("t1_ready", 32'(UART_DATA_READY), 32'd1);
    step();
    check("t1_ack", 32'(REQ_ACK), 32'h4);
    wait_done(100);

    // Pointer to 0 via requester 3, then all four valid
    clear_src();
    load(3, 8'h77, 1'b1);
    push(4'b1000, 8'h77);
    drive_reqs();
    wait_done(100);
    clear_src();
    last_take = -1;
    chk_rate  = 1'b1;
    base      = take_cnt;
    load(0, 8'hA0, 1'b0);
    load(0, 8'hB0, 1'b1);
    load(1, 8'hA1, 1'b1);
    load(2, 8'hA2, 1'b1);
    load(3, 8'hA3, 1'b1);
`ifdef UART_ARB_LOCK_EN
    push(4'b0001, 8'hA0);
    push(4'b0001, 8'hB0);
    push(4'b0010, 8'hA1);
    push(4'b0100, 8'hA2);
    push(4'b1000, 8'hA3);
`else
    push(4'b0001, 8'hA0);
    push(4'b0010, 8'hA1);
    push(4'b0100, 8'hA2);
    push(4'b1000, 8'hA3);
    push(4'b0001, 8'hB0);
`endif
    drive_reqs();
    wait_done(200);
    chk_rate = 1'b0;
    check("t2_count", 32'(take_cnt - base), 32'd5);

    // Transmitter busy for 50 cycles during SEND
    clear_src();
    load(0, 8'h99, 1'b1);
    push(4'b0001, 8'h99);
    drive_reqs();
    @(posedge CLK);
    #1;
    force_busy = 1'b1;
    UART_IDLE  = 1'b0;
    repeat (50) begin
      step();
      check("t3_ready", 32'(UART_DATA_READY), 32'd1);
      check("t3_noack", 32'(REQ_ACK), 32'd0);
    end
    force_busy = 1'b0;
    wait_done(100);

    // VALID dropped during SEND: registered byte still sent once
    clear_src();
    load(2, 8'h3C, 1'b1);
    push(4'b0100, 8'h3C);
    drive_reqs();
    @(posedge CLK);
    #1;
    force_busy = 1'b1;
    UART_IDLE  = 1'b0;
    kill[2]    = 1'b1;
    drive_reqs();
    repeat (5) step();
    check("t4_ready", 32'(UART_DATA_READY), 32'd1);
    check("t4_data_held", 32'(UART_DATA), 32'h3C);
    force_busy = 1'b0;
    wait_done(100);
    repeat (10) step();

    // Reset in SEND aborts; afterwards lowest valid index goes first
    clear_src();
    load(1, 8'h11, 1'b1);
    load(3, 8'h33, 1'b1);
    drive_reqs();
    @(posedge CLK);
    #1;
    force_busy = 1'b1;
    UART_IDLE  = 1'b0;
    step();
    check("t5_pre_grant", 32'(GRANT), 32'h8);
    #2;
    RST_N = 1'b0;
    #1;
    check("t5_rst_grant", 32'(GRANT), 32'd0);
    check("t5_rst_ack", 32'(REQ_ACK), 32'd0);
    check("t5_rst_data", 32'(UART_DATA), 32'd0);
    check("t5_rst_ready", 32'(UART_DATA_READY), 32'd0);
    step();
    step();
    RST_N      = 1'b1;
    force_busy = 1'b0;
    UART_IDLE  = 1'b1;
    push(4'b0010, 8'h11);
    push(4'b1000, 8'h33);
    wait_done(200);

`ifdef UART_ARB_LOCK_EN
    // Packet lock: requester 1 keeps the line for its three bytes
    clear_src();
    load(0, 8'h01, 1'b1);
    push(4'b0001, 8'h01);
    drive_reqs();
    wait_done(100);
    clear_src();
    load(1, 8'h21, 1'b0);
    load(1, 8'h22, 1'b0);
    load(1, 8'h23, 1'b1);
    load(0, 8'h02, 1'b1);
    load(3, 8'h03, 1'b1);
    push(4'b0010, 8'h21);
    push(4'b0010, 8'h22);
    push(4'b0010, 8'h23);
    push(4'b1000, 8'h03);
    push(4'b0001, 8'h02);
    drive_reqs();
    wait_done(300);

    // Lock timeout: owner goes quiet after a non-last byte
    clear_src();
    load(1, 8'h31, 1'b0);
    load(2, 8'h32, 1'b1);
    push(4'b0010, 8'h31);
    push(4'b0100, 8'h32);
    drive_reqs();
    n = 0;
    while (!REQ_ACK[1] && n < 100) begin
      step();
      n++;
    end
    check("t7_ack_seen", 32'(n < 100), 32'd1);
    step();
    k = 0;
    while (GRANT == 0 && k < 100) begin
      step();
      k++;
    end
    check("t7_timeout_cycles", 32'(k), 32'(LT));
    wait_done(100);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
